load_store_unit: RTL
====================

# load_store_unit

Memory-stage load/store unit for the RV32I pipeline. It sits between the EX/MEM pipeline register and the word-wide data memory. It converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses. Sub-word stores use a two-cycle read-modify-write, because the memory has only a whole-word write enable. Loaded data is lane-selected and extended before it is returned to the writeback path.

## Interface
- `MEM_AW`, default 10, meaning: width of the word index presented to data memory (1024 words).
- `clk`, in, 1, meaning: system clock; all state updates on the rising edge.
- `rst`, in, 1, meaning: synchronous reset, active-high.
- `req_valid`, in, 1, meaning: request present.
- `req_ready`, out, 1, meaning: the unit accepts a request this cycle.
- `req_we`, in, 1, meaning: 1 = store, 0 = load.
- `req_size`, in, 2, meaning: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned`, in, 1, meaning: zero-extend loads (LBU/LHU).
- `req_addr`, in, 32, meaning: byte address.
- `req_wdata`, in, 32, meaning: store data, right-justified.
- `resp_valid`, out, 1, meaning: one-cycle completion pulse.
- `resp_rdata`, out, 32, meaning: extended load data; 0 for stores and errors.
- `resp_err`, out, 1, meaning: misaligned or illegal access, qualified by `resp_valid`.
- `mem_addr`, out, 32, meaning: word index `{(32-MEM_AW)'b0, addr[MEM_AW+1:2]}`.
- `mem_we`, out, 1, meaning: word write strobe; memory writes on the next rising edge.
- `mem_wd`, out, 32, meaning: word write data.
- `mem_rd`, in, 32, meaning: combinational read data for `mem_addr`.

## Operation
States: IDLE, MERGE, RESP.

- **IDLE**
  - `req_ready`=1 and `mem_addr` is taken from `req_addr`.
  - A request is accepted when `req_valid`=1. On acceptance, addr, size, unsigned and wdata are latched.
- **Accepted load**
  - `mem_rd` is captured, lane-selected and extended into `resp_rdata_q`.
  - Next state is RESP.
- **Accepted word store**
  - `mem_we`=1 and `mem_wd`=`req_wdata` in the accept cycle.
  - Next state is RESP.
- **Accepted byte/half store**
  - `mem_rd` is captured into `rmw_q`. No write happens in the accept cycle.
  - Next state is MERGE.
- **MERGE**
  - `mem_addr` comes from the latched address.
  - `mem_we`=1.
  - `mem_wd` = `rmw_q` with the target lane(s) replaced by the low byte or half of the latched wdata.
  - Next state is RESP.
- **RESP**
  - `resp_valid`=1 for exactly one cycle and `req_ready`=0.
  - Next state is IDLE.
- **Lanes (little-endian)**
  - Byte lane = addr[1:0].
  - Half lane = addr[1] (bits 15:0 or 31:16).
- **Load extension**
  - Signed loads replicate bit 7 or bit 15.
  - Unsigned loads zero-fill.
- **Misaligned access**: half with addr[0]=1, or word with addr[1:0]≠0. Handling is governed by the Configuration section.
- **Illegal size**: `req_size`=11.
- **`req_ready` in MERGE and RESP**: 0. Requests presented then are not accepted, so the pipeline stalls on `~req_ready`.

## Timing
- **Reset values**: state=IDLE, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_we`=0, `req_ready`=0 while `rst`=1, `rmw_q`=0.
- **Latency**, from the accept edge to `resp_valid`:
  - load: 1 cycle
  - word store: 1 cycle
  - byte/half store: 2 cycles
  - error: 1 cycle
- **Throughput**: one load or word store every 2 cycles; one sub-word store every 3 cycles.
- **Output decoding**: `mem_we` and `mem_wd` are combinational from state and the accept condition. `mem_we` is never asserted in RESP or during reset.
- **Reset during MERGE**: the write is suppressed, memory is unchanged and no response is produced.
- **Hazard**: none internal. RMW read and write target the same latched word in consecutive cycles, and no other request can intervene.

## Configuration
- **With `LSU_MISALIGN_TRAP_EN` defined**
  - A misaligned access or `req_size`=11 is accepted normally.
  - No memory access happens: `mem_we` stays 0.
  - RESP follows with `resp_err`=1 and `resp_rdata`=0.
- **Without `LSU_MISALIGN_TRAP_EN`**
  - Offending low address bits are forced to zero: addr[0] for half, addr[1:0] for word.
  - `req_size`=11 is treated as word.
  - `resp_err` is tied to 0.

## Test plan
- **LB sign extension**: preload word 7 = 0x000000AB; LB addr 0x1C → `resp_rdata`=0xFFFFFFAB after 1 cycle. LBU from the same address → 0x000000AB.
- **LH upper lane**: word 2 = 0x8001_1234; LH addr 0x0A → 0xFFFF8001. LHU addr 0x08 → 0x00001234.
- **SB read-modify-write**: word 3 = 0x11223344; SB addr 0x0D wdata 0xFFFFFF99 → MERGE writes 0x11229944. `resp_valid` 2 cycles after accept and `req_ready`=0 for 2 cycles.
- **SW then back-to-back LW**: SW addr 0x20 wdata 0xDEADBEEF with `req_valid` held high → LW addr 0x20 is accepted the cycle after RESP and returns 0xDEADBEEF.
- **Misalignment**
  - With `LSU_MISALIGN_TRAP_EN`: SW addr 0x22 → `resp_err`=1 and word 8 is unchanged.
  - Without it: SW addr 0x22 → word 8 is written and `resp_err`=0.
- **Reset mid-RMW**: SH addr 0x10 with `rst` asserted during MERGE → word 4 is unchanged, no `resp_valid`, and `req_ready`=1 one cycle after reset is released.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I memory-stage load/store unit with sub-word read-modify-write
// Optional LSU_MISALIGN_TRAP_EN: misaligned/illegal accesses report resp_err instead of being aligned.
module load_store_unit #(
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, MERGE, RESP} state_t;

  state_t              state_q, state_d;
  logic [MEM_AW+1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [31:0]         rmw_q, rmw_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

  logic                accept;
  logic [1:0]          size_eff;
  logic [31:0]         addr_eff;
  logic                bad_access;
  logic [MEM_AW+1:0]   addr_sel;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:MEM_AW+2];

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] sh;
    sh = w >> {a, 3'b000};
    case (sz)
      2'b00:   load_ext = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   load_ext = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_ext = w;
    endcase
  endfunction

  // Replace only the addressed byte/half of the word read in the accept cycle.
  function automatic logic [31:0] merge_lane(input logic [31:0] old, input logic [15:0] wd,
                                             input logic [1:0] a, input logic [1:0] sz);
    logic [31:0] mask;
    logic [31:0] data;
    if (sz == 2'b00) begin
      mask = 32'h0000_00FF << {a, 3'b000};
      data = {4{wd[7:0]}};
    end else begin
      mask = 32'h0000_FFFF << {a[1], 4'b0000};
      data = {2{wd}};
    end
    merge_lane = (old & ~mask) | (data & mask);
  endfunction

  assign req_ready  = (state_q == IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  always_comb begin
    addr_eff = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
    size_eff   = req_size;
    bad_access = (req_size == 2'b11) ||
                 (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
    size_eff   = (req_size == 2'b11) ? 2'b10 : req_size;
    bad_access = 1'b0;
    if (size_eff == 2'b01) addr_eff[0] = 1'b0;
    if (size_eff == 2'b10) addr_eff[1:0] = 2'b00;
`endif
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    wdata_d      = wdata_q;
    rmw_d        = rmw_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_we       = 1'b0;
    mem_wd       = 32'h0;
    addr_sel     = (state_q == IDLE) ? addr_eff[MEM_AW+1:0] : addr_q;

    case (state_q)
      IDLE: begin
        mem_wd = req_wdata;
        if (accept) begin
          addr_d       = addr_eff[MEM_AW+1:0];
          size_d       = size_eff;
          unsigned_d   = req_unsigned;
          wdata_d      = req_wdata[15:0];
          resp_rdata_d = 32'h0;
          resp_err_d   = bad_access;
          state_d      = RESP;
          if (!bad_access) begin
            if (!req_we) begin
              resp_rdata_d = load_ext(mem_rd, addr_eff[1:0], size_eff, req_unsigned);
            end else if (size_eff == 2'b10) begin
              mem_we = 1'b1;
            end else begin
              rmw_d   = mem_rd;
              state_d = MERGE;
            end
          end
        end
      end
      MERGE: begin
        mem_we  = 1'b1;
        mem_wd  = merge_lane(rmw_q, wdata_q, addr_q[1:0], size_q);
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A reset landing in MERGE must leave memory untouched.
    if (rst) mem_we = 1'b0;

    mem_addr = 32'h0;
    mem_addr[MEM_AW-1:0] = addr_sel[MEM_AW+1:2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      wdata_q      <= 16'h0;
      rmw_q        <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      wdata_q      <= wdata_d;
      rmw_q        <= rmw_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule
